// File: rtl/cpu_clock_reset_seq.sv
// CPU PLL power-up/lock supervisor: drives PLL reset, qualifies the synchronized lock, gates system reset.
// Latency: sysReset releases PLL_RST_CYCLES+1+STABLE_CYCLES edges after reset with lock steady; no backpressure.
module cpu_clock_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       locked,
    output logic       pllReset,
    output logic       sysReset,
    output logic       ready,
    output logic [7:0] retryCount,
    output logic [1:0] state
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    retry_d;
    logic [7:0]    retry_sat;
    logic          lock_s1;
    logic          lock_sync;

    // locked comes straight from the PLL; only lock_sync may reach the FSM
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_s1   <= locked;
            lock_sync <= lock_s1;
        end
    end

    assign retry_sat = (retryCount == 8'hFF) ? retryCount : retryCount + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retryCount;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_sat;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                // a lock drop outranks reaching the terminal count
                if (!lock_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_sat;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // outputs are registered from the next state so they change on the same edge as state
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            retryCount <= 8'd0;
            pllReset   <= 1'b1;
            sysReset   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retryCount <= retry_d;
            pllReset   <= (state_d == PLL_RST);
            sysReset   <= (state_d != RUN);
            ready      <= (state_d == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_clock_reset_seq.sv
// Bench for cpu_clock_reset_seq: vector table, hand-built corner sequences and a random lock waveform
// compared against a cycle-level reference model of the supervisor rules.
module tb_cpu_clock_reset_seq;

    localparam int P = 4;
    localparam int T = 50;
    localparam int S = 8;

    logic       clkin  = 1'b0;
    logic       reset  = 1'b1;
    logic       locked = 1'b0;
    logic       pllReset;
    logic       sysReset;
    logic       ready;
    logic [7:0] retryCount;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;
    bit mdl_en = 1'b0;

    cpu_clock_reset_seq #(
        .PLL_RST_CYCLES(P),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .locked    (locked),
        .pllReset  (pllReset),
        .sysReset  (sysReset),
        .ready     (ready),
        .retryCount(retryCount),
        .state     (state)
    );

    always #5 clkin = ~clkin;

    // reference: phase 0..3, n = cycles completed in phase, two-deep lock history
    typedef struct {
        int   phase;
        int   n;
        int   retries;
        logic sy1;
        logic sy2;
    } mdl_t;

    mdl_t mdl = '{0, 0, 0, 1'b0, 1'b0};

    function automatic int sat_inc(int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic rst, logic lk);
        mdl_t r;
        logic ls;
        r     = m;
        ls    = m.sy2;
        r.sy2 = m.sy1;
        r.sy1 = lk;
        if (rst) begin
            r = '{0, 0, 0, 1'b0, 1'b0};
            return r;
        end
        case (m.phase)
            0: begin
                r.n = m.n + 1;
                if (r.n == P) begin r.phase = 1; r.n = 0; end
            end
            1: begin
                if (ls) begin
                    r.phase = 2; r.n = 0;
                end else begin
                    r.n = m.n + 1;
                    if (r.n == T) begin r.phase = 0; r.n = 0; r.retries = sat_inc(m.retries); end
                end
            end
            2: begin
                if (!ls) begin
                    r.phase = 1; r.n = 0;
                end else begin
                    r.n = m.n + 1;
                    if (r.n == S) r.phase = 3;
                end
            end
            default: begin
                if (!ls) begin r.phase = 0; r.n = 0; r.retries = sat_inc(m.retries); end
            end
        endcase
        return r;
    endfunction

    function automatic logic [12:0] mexp(mdl_t m);
        return {2'(m.phase), m.phase == 0, m.phase != 3, m.phase == 3, 8'(m.retries)};
    endfunction

    function automatic logic [12:0] outs();
        return {state, pllReset, sysReset, ready, retryCount};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l);
        reset  = r;
        locked = l;
        @(posedge clkin);
        @(negedge clkin);
    endtask

    always @(posedge clkin) mdl <= mstep(mdl, reset, locked);

    always @(negedge clkin) begin
        if (mdl_en) check("model", outs(), mexp(mdl));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic       lck;
        logic [1:0] st;
        logic       pll;
        logic       sys;
        logic       rdy;
        logic [7:0] rc;
    } vec_t;

    vec_t vt[17];

    initial begin
        // nominal bring-up, one entry per edge: 3 reset edges then 14 edges with lock held
        for (int i = 0; i < 3; i++)   vt[i] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
        for (int i = 3; i < 6; i++)   vt[i] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
        vt[6] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0};
        for (int i = 7; i < 15; i++)  vt[i] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0};
        for (int i = 15; i < 17; i++) vt[i] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'd0};

        mdl_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(vt[i].rst, vt[i].lck);
            check($sformatf("vec%0d", i), outs(),
                  {vt[i].st, vt[i].pll, vt[i].sys, vt[i].rdy, vt[i].rc});
        end

        // loss of lock in RUN: two synchronizer edges, then the FSM edge
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("lol_still_run", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 8'd0});
        step(1'b0, 1'b0);
        check("lol_to_pll_rst", outs(), {2'd0, 1'b1, 1'b1, 1'b0, 8'd1});
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("lol_relock_stable", outs(), {2'd2, 1'b0, 1'b1, 1'b0, 8'd1});
        step(1'b0, 1'b1);
        check("lol_relock_run", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 8'd1});

        // reset in RUN, then in STABLE, then nominal restart
        step(1'b1, 1'b1);
        check("rst_in_run", outs(), {2'd0, 1'b1, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        check("pre_rst_stable", state, 2'd2);
        step(1'b1, 1'b1);
        check("rst_in_stable", outs(), {2'd0, 1'b1, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("restart_edge12", outs(), {2'd2, 1'b0, 1'b1, 1'b0, 8'd0});
        step(1'b0, 1'b1);
        check("restart_edge13", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 8'd0});

        // 3-cycle lock glitch midway through STABLE
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("glitch_to_wait", outs(), {2'd1, 1'b0, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check("glitch_requal_hold", outs(), {2'd2, 1'b0, 1'b1, 1'b0, 8'd0});
        step(1'b0, 1'b1);
        check("glitch_requal_run", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 8'd0});

        // lock drop seen exactly when the STABLE counter is terminal
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("bnd_edge11", state, 2'd2);
        step(1'b0, 1'b1);
        check("bnd_edge12", state, 2'd2);
        step(1'b0, 1'b1);
        check("bnd_drop_wins", outs(), {2'd1, 1'b0, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        // random lock waveform with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            logic lk;
            logic rs;
            int   len;
            lk  = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 39) == 0);
            len = $urandom_range(1, 40);
            for (int j = 0; j < len; j++) step(rs && (j == 0), lk);
        end

        // lock never arrives: periodic retries, then saturation
        mdl_en = 1'b0;
        step(1'b1, 1'b0);
        for (int e = 1; e <= 54 * 256 + 8; e++) begin
            step(1'b0, 1'b0);
            if (e <= 162)
                check($sformatf("tmo_e%0d", e), {pllReset, sysReset, retryCount},
                      {((e % 54) < 4), 1'b1, 8'(e / 54)});
            if (e == 54 * 255 - 1) check("sat_pre", retryCount, 8'd254);
            if (e == 54 * 255)     check("sat_reach", retryCount, 8'd255);
            if (e == 54 * 256)
                check("sat_hold_retry", {state, pllReset, retryCount}, {2'd0, 1'b1, 8'd255});
        end
        check("sat_final", {sysReset, ready, retryCount}, {1'b1, 1'b0, 8'd255});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
